controle_busca: RTL and testbench

Fetch-stage sequencer between the PC/branch-target logic and a variable-latency instruction memory. It owns the program counter. It issues one fetch request at a time and holds at most two fetched instructions (output buffer plus one pending slot) while decode is stalled. On a taken branch it flushes wrong-path instructions and discards any in-flight memory response. It replaces the free-running PC path and delivers `instrucao`/`pc4_out` with a valid flag to the IF/ID register.

---
 rtl/controle_busca_pkg.sv | 18 +
 rtl/controle_busca.sv | 147 ++++++++++++++
 tb/tb_controle_busca.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/controle_busca_pkg.sv
// pacote_busca: definitions shared by the fetch sequencer and anything that
// instantiates it.
//   - estado_t: 2-bit encoding of the fetch FSM states
//   - default width, reset PC and sequential step
package pacote_busca;

    localparam int unsigned LARGURA_PAD    = 32;
    localparam int unsigned PC_RESET_PAD   = 32'h0000_0000;
    localparam int unsigned INCREMENTO_PAD = 4;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        BUSCA    = 2'd1,
        CHEIO    = 2'd2,
        DESCARTE = 2'd3
    } estado_t;

endpackage

// File: rtl/controle_busca.sv
// controle_busca: fetch-stage sequencer between PC/branch logic and a
// variable-latency instruction memory. It owns the PC, keeps one request in
// flight, and buffers up to two instructions (output buffer + pending slot)
// while decode stalls. A redirect flushes both and drops any in-flight response.
//
// Ports
//   clock, reset_n           clock (rising edge), async active-low reset
//   stall                    decode cannot take the buffered instruction
//   PCSrc, endereco_desvio   redirect request and its target
//   mem_req, mem_endereco    fetch request and address (decoded from regs)
//   mem_pronto, mem_dado     memory response strobe and instruction word
//   instrucao, pc4_out       buffered instruction and its address + step
//   valido                   instrucao/pc4_out hold a valid instruction
//
// state    | meaning
// OCIOSO   | just out of reset, no request yet
// BUSCA    | request for pc outstanding, buffer may hold one word
// CHEIO    | buffer and pending slot both full, no request
// DESCARTE | redirected while a request was in flight; drop its response
module controle_busca
    import pacote_busca::*;
#(
    parameter int unsigned LARGURA    = LARGURA_PAD,
    parameter int unsigned PC_RESET   = PC_RESET_PAD,
    parameter int unsigned INCREMENTO = INCREMENTO_PAD
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               PCSrc,
    input  logic [LARGURA-1:0] endereco_desvio,
    output logic               mem_req,
    output logic [LARGURA-1:0] mem_endereco,
    input  logic               mem_pronto,
    input  logic [LARGURA-1:0] mem_dado,
    output logic [LARGURA-1:0] instrucao,
    output logic [LARGURA-1:0] pc4_out,
    output logic               valido
);

    localparam logic [LARGURA-1:0] PASSO   = LARGURA'(INCREMENTO);
    localparam logic [LARGURA-1:0] PC_INIC = LARGURA'(PC_RESET);

    estado_t            estado, proximo;
    logic [LARGURA-1:0] pc;
    logic [LARGURA-1:0] pc_antigo;
    logic [LARGURA-1:0] pend_instr;
    logic [LARGURA-1:0] pend_pc4;
    logic [LARGURA-1:0] pc_mais;
    logic               consumo;

    // Wraps modulo 2^LARGURA by construction.
    assign pc_mais = pc + PASSO;
    assign consumo = valido && !stall;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO: proximo = BUSCA;
            BUSCA: begin
                if (PCSrc) begin
                    proximo = mem_pronto ? BUSCA : DESCARTE;
                end else if (mem_pronto && valido && stall) begin
                    proximo = CHEIO;
                end
            end
            CHEIO: begin
                if (PCSrc || consumo) begin
                    proximo = BUSCA;
                end
            end
            DESCARTE: begin
                if (!PCSrc && mem_pronto) begin
                    proximo = BUSCA;
                end
            end
            default: proximo = OCIOSO;
        endcase
    end

    // In DESCARTE the memory still serves the old request, so its address is
    // held from pc_antigo while pc already carries the redirect target.
    always_comb begin
        mem_req      = (estado == BUSCA) || (estado == DESCARTE);
        mem_endereco = (estado == DESCARTE) ? pc_antigo : pc;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc         <= PC_INIC;
            pc_antigo  <= '0;
            instrucao  <= '0;
            pc4_out    <= '0;
            valido     <= 1'b0;
            pend_instr <= '0;
            pend_pc4   <= '0;
        end else if (PCSrc) begin
            valido     <= 1'b0;
            pend_instr <= '0;
            pend_pc4   <= '0;
            pc         <= endereco_desvio;
            // A repeated redirect in DESCARTE must keep the address of the
            // request that is really outstanding.
            if (estado == BUSCA) begin
                pc_antigo <= pc;
            end
        end else begin
            case (estado)
                BUSCA: begin
                    if (mem_pronto) begin
                        pc <= pc_mais;
                        if (!valido || !stall) begin
                            instrucao <= mem_dado;
                            pc4_out   <= pc_mais;
                            valido    <= 1'b1;
                        end else begin
                            pend_instr <= mem_dado;
                            pend_pc4   <= pc_mais;
                        end
                    end else if (consumo) begin
                        valido <= 1'b0;
                    end
                end
                CHEIO: begin
                    if (consumo) begin
                        instrucao <= pend_instr;
                        pc4_out   <= pend_pc4;
                    end
                end
                default: begin
                    if (consumo) begin
                        valido <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controle_busca.sv
// tb_controle_busca: directed test of the fetch sequencer. Inputs change 1 ns
// after each rising edge, outputs are checked at that same point.
module tb_controle_busca;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        stall = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] endereco_desvio = '0;
    logic        mem_req;
    logic [31:0] mem_endereco;
    logic        mem_pronto = 1'b0;
    logic [31:0] mem_dado = '0;
    logic [31:0] instrucao;
    logic [31:0] pc4_out;
    logic        valido;

    int avaliadas = 0;
    int falhas = 0;

    controle_busca dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .stall           (stall),
        .PCSrc           (PCSrc),
        .endereco_desvio (endereco_desvio),
        .mem_req         (mem_req),
        .mem_endereco    (mem_endereco),
        .mem_pronto      (mem_pronto),
        .mem_dado        (mem_dado),
        .instrucao       (instrucao),
        .pc4_out         (pc4_out),
        .valido          (valido)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        avaliadas++;
        assert (obs === esp) else begin
            falhas++;
            $error("FAIL %s: observed %h expected %h", tag, obs, esp);
        end
    endtask

    initial begin
        logic [31:0] addr;

        // reset state
        #2 reset_n = 1'b0;
        #1;
        verifica("rst_mem_req", 32'(mem_req), 32'd0);
        verifica("rst_valido", 32'(valido), 32'd0);
        verifica("rst_instrucao", instrucao, 32'h0);
        verifica("rst_pc4", pc4_out, 32'h0);
        verifica("rst_endereco", mem_endereco, 32'h0);
        tick();
        tick();
        reset_n = 1'b1;

        // zero-wait streaming
        verifica("ocioso_mem_req", 32'(mem_req), 32'd0);
        mem_pronto = 1'b1;
        mem_dado   = 32'h0;
        tick();
        verifica("primeira_req", 32'(mem_req), 32'd1);
        verifica("primeiro_end", mem_endereco, 32'h0);
        verifica("primeiro_valido", 32'(valido), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            verifica("stream_valido", 32'(valido), 32'd1);
            verifica("stream_instr", instrucao, 32'(4 * i));
            verifica("stream_pc4", pc4_out, 32'(4 * i + 4));
            verifica("stream_end", mem_endereco, 32'(4 * i + 4));
            mem_dado = 32'(4 * i + 4);
            tick();
        end
        verifica("stream_fim_instr", instrucao, 32'd16);
        verifica("stream_fim_end", mem_endereco, 32'd20);

        // response every third cycle
        addr = 32'd20;
        for (int r = 0; r < 2; r++) begin
            mem_pronto = 1'b0;
            tick();
            verifica("espera_valido", 32'(valido), 32'd0);
            verifica("espera_end_a", mem_endereco, addr);
            tick();
            verifica("espera_end_b", mem_endereco, addr);
            mem_pronto = 1'b1;
            mem_dado   = addr;
            tick();
            verifica("resp_valido", 32'(valido), 32'd1);
            verifica("resp_instr", instrucao, addr);
            verifica("resp_pc4", pc4_out, addr + 32'd4);
            addr = addr + 32'd4;
        end

        // stall fills buffer and pending slot
        stall    = 1'b1;
        mem_dado = 32'd28;
        tick();
        for (int k = 0; k < 3; k++) begin
            verifica("cheio_mem_req", 32'(mem_req), 32'd0);
            verifica("cheio_valido", 32'(valido), 32'd1);
            verifica("cheio_instr", instrucao, 32'd24);
            mem_dado = 32'hBAD0_0000;
            tick();
        end
        verifica("cheio_fim_instr", instrucao, 32'd24);
        stall = 1'b0;
        tick();
        verifica("pend_instr", instrucao, 32'd28);
        verifica("pend_pc4", pc4_out, 32'd32);
        verifica("pend_valido", 32'(valido), 32'd1);
        verifica("pend_mem_req", 32'(mem_req), 32'd1);
        verifica("pend_end", mem_endereco, 32'd32);
        mem_dado = 32'd32;
        tick();
        verifica("apos_pend_instr", instrucao, 32'd32);
        verifica("apos_pend_pc4", pc4_out, 32'd36);
        verifica("apos_pend_end", mem_endereco, 32'd36);

        // redirect while request outstanding
        mem_pronto      = 1'b0;
        PCSrc           = 1'b1;
        endereco_desvio = 32'h100;
        tick();
        PCSrc = 1'b0;
        verifica("desc_valido", 32'(valido), 32'd0);
        verifica("desc_mem_req", 32'(mem_req), 32'd1);
        verifica("desc_end_antigo", mem_endereco, 32'd36);
        tick();
        verifica("desc_end_antigo2", mem_endereco, 32'd36);
        mem_pronto = 1'b1;
        mem_dado   = 32'hDEAD_BEEF;
        tick();
        verifica("desc_descartado", 32'(valido), 32'd0);
        verifica("desc_novo_end", mem_endereco, 32'h100);
        mem_dado = 32'h100;
        tick();
        verifica("alvo_valido", 32'(valido), 32'd1);
        verifica("alvo_instr", instrucao, 32'h100);
        verifica("alvo_pc4", pc4_out, 32'h104);

        // redirect in CHEIO with stall
        stall    = 1'b1;
        mem_dado = 32'h104;
        tick();
        verifica("cheio2_mem_req", 32'(mem_req), 32'd0);
        PCSrc           = 1'b1;
        endereco_desvio = 32'h200;
        mem_pronto      = 1'b0;
        tick();
        PCSrc = 1'b0;
        verifica("cheio_desv_valido", 32'(valido), 32'd0);
        verifica("cheio_desv_req", 32'(mem_req), 32'd1);
        verifica("cheio_desv_end", mem_endereco, 32'h200);
        mem_pronto = 1'b1;
        mem_dado   = 32'h200;
        tick();
        verifica("cheio_alvo_instr", instrucao, 32'h200);
        verifica("cheio_alvo_pc4", pc4_out, 32'h204);
        verifica("cheio_alvo_valido", 32'(valido), 32'd1);
        stall      = 1'b0;
        mem_pronto = 1'b0;
        tick();
        verifica("pend_limpo", 32'(valido), 32'd0);

        // redirect with response in same cycle, then PC wrap
        PCSrc           = 1'b1;
        endereco_desvio = 32'hFFFF_FFFC;
        mem_pronto      = 1'b1;
        mem_dado        = 32'h1234_5678;
        tick();
        PCSrc = 1'b0;
        verifica("desv_imed_end", mem_endereco, 32'hFFFF_FFFC);
        verifica("desv_imed_valido", 32'(valido), 32'd0);
        mem_dado = 32'hCAFE_F00D;
        tick();
        verifica("wrap_pc4", pc4_out, 32'h0);
        verifica("wrap_instr", instrucao, 32'hCAFE_F00D);
        verifica("wrap_end", mem_endereco, 32'h0);
        verifica("wrap_mem_req", 32'(mem_req), 32'd1);

        // asynchronous reset mid-request
        mem_pronto = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        verifica("rst_async_req", 32'(mem_req), 32'd0);
        verifica("rst_async_valido", 32'(valido), 32'd0);
        verifica("rst_async_instr", instrucao, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        verifica("rst_retoma_req", 32'(mem_req), 32'd1);
        verifica("rst_retoma_end", mem_endereco, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", avaliadas, falhas);
        $finish;
    end

endmodule
